// File: rtl/imem_loader.sv
// Instruction-memory loader: streams words into IMEM at consecutive word
// addresses, holds the core idle while loading, then releases it with the
// start PC of the loaded image.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_CNT_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_pc,
  input  logic [MAX_CNT_W-1:0] word_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 im_we,
  output logic [31:0]          im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_hold,
  output logic [31:0]          cpu_start_pc,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  state_t               state, state_n;
  logic [31:0]          base_q;
  logic [MAX_CNT_W-1:0] idx, remain;
  logic [31:0]          end_word;
  logic [31:0]          mem_words;
  logic                 req_ok, can_start, accept, xfer, last;

  // One past the last word index the request touches; cannot overflow 32 bits
  // because base_pc[31:2] is only 30 bits wide.
  assign end_word  = {2'b00, base_pc[31:2]} + {{(32-MAX_CNT_W){1'b0}}, word_count};
  assign mem_words = 32'd1 << ADDR_W;
  assign req_ok    = (base_pc[1:0] == 2'b00) && (word_count != '0) && (end_word <= mem_words);
  // Starts are only looked at when no load is in flight.
  assign can_start = (state == IDLE) || (state == RUN);
  assign accept    = start && can_start && req_ok;
  assign xfer      = (state == LOAD) && in_valid && in_ready;
  assign last      = (remain == MAX_CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = LOAD;
      LOAD:    if (xfer && last) state_n = RELEASE;
      RELEASE: state_n = RUN;
      RUN:     if (accept) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, word counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      idx          <= '0;
      remain       <= '0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b1;
      cpu_start_pc <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_pc;
        idx    <= '0;
        remain <= word_count;
      end else if (xfer) begin
        idx    <= idx + 1'b1;
        remain <= remain - 1'b1;
      end

      // Rejection is sticky until the next accepted start.
      if (start && can_start) err <= !req_ok;

      in_ready <= (state_n == LOAD);
      im_we    <= xfer;
      if (xfer) begin
        im_addr  <= base_q + {{(30-MAX_CNT_W){1'b0}}, idx, 2'b00};
        im_wdata <= in_data;
      end

      if (state == RELEASE) cpu_start_pc <= base_q;

      // Core runs only once RUN has been reached and no reload is starting.
      cpu_hold <= (state == RUN) ? accept : 1'b1;
      done     <= (state == RUN) && !accept;
      busy     <= (state_n == LOAD) || (state_n == RELEASE) || (state == RELEASE);
    end
  end

endmodule
